// File: rtl/max1119x_conv_sched.sv
// MAX1119x SPI ADC conversion scheduler: period/single-shot frame start, 16-bit MSB-first capture, AXIS output.
// Optional MAX1119X_DROP_CNT_EN adds a saturating count of discarded samples on drop_count.
module max1119x_conv_sched #(
  parameter int CLK_DIV      = 2,
  parameter int QUIET_CYCLES = 4,
  parameter int PERIOD_W     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                single_shot,
  input  logic                miso,
  output logic                cs_n,
  output logic                sclk,
  output logic                busy,
  output logic [15:0]         m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                overrun,
  output logic                missed_tick,
`ifdef MAX1119X_DROP_CNT_EN
  output logic [15:0]         drop_count,
`endif
  input  logic                flags_clr
);

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, QUIET} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [4:0]          half;
  logic [15:0]         sr;
  logic                pending;
  logic                enable_q;
  logic [PERIOD_W-1:0] tmr;
  logic [PERIOD_W-1:0] period_cur;

  logic       first, tick, level, start_any, can_start, hold_done, div_done;
  logic [1:0] reqs;

  always_comb begin
    first     = enable & ~enable_q;
    tick      = enable & enable_q & (period_cur != '0) & (tmr == period_cur - PERIOD_W'(1));
    // period==0 is a level request: it never queues or counts as a missed start
    level     = enable & enable_q & (period_cur == '0);
    reqs      = {1'b0, first} + {1'b0, tick} + {1'b0, single_shot};
    start_any = pending | (reqs != 2'd0) | level;
    div_done  = (cnt == CNT_W'(CLK_DIV - 1));
    hold_done = (state == CS_HOLD) && div_done;
    can_start = (state == IDLE) || ((state == QUIET) && (cnt == CNT_W'(QUIET_CYCLES - 1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      half          <= '0;
      sr            <= '0;
      pending       <= 1'b0;
      enable_q      <= 1'b0;
      tmr           <= '0;
      period_cur    <= '0;
      cs_n          <= 1'b1;
      sclk          <= 1'b0;
      busy          <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun       <= 1'b0;
      missed_tick   <= 1'b0;
`ifdef MAX1119X_DROP_CNT_EN
      drop_count    <= '0;
`endif
    end else begin
      enable_q <= enable;

      if (!enable) begin
        tmr <= '0;
      end else if (first || tick) begin
        tmr        <= '0;
        period_cur <= period;
      end else begin
        tmr <= tmr + PERIOD_W'(1);
      end

      // A request that cannot start a frame queues once; any further one is lost
      if (can_start && start_any) begin
        pending <= 1'b0;
      end else if (reqs != 2'd0) begin
        if (pending || reqs[1]) missed_tick <= 1'b1;
        pending <= 1'b1;
      end
      if (enable_q && !enable) pending <= 1'b0;

      case (state)
        IDLE: begin
          if (start_any) begin
            state <= CS_SETUP;
            cs_n  <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        CS_SETUP: begin
          if (div_done) begin
            cnt   <= '0;
            half  <= '0;
            sclk  <= 1'b1;
            sr    <= {sr[14:0], miso};
            state <= SHIFT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (div_done) begin
            cnt <= '0;
            if (half == 5'd31) begin
              sclk  <= 1'b0;
              state <= CS_HOLD;
            end else begin
              half <= half + 5'd1;
              sclk <= ~sclk;
              if (!sclk) sr <= {sr[14:0], miso};
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CS_HOLD: begin
          if (div_done) begin
            cnt   <= '0;
            cs_n  <= 1'b1;
            state <= QUIET;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        QUIET: begin
          if (cnt == CNT_W'(QUIET_CYCLES - 1)) begin
            cnt <= '0;
            if (start_any) begin
              state <= CS_SETUP;
              cs_n  <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (hold_done) begin
        if (!m_axis_tvalid || m_axis_tready) begin
          m_axis_tdata  <= sr;
          m_axis_tvalid <= 1'b1;
        end else begin
          overrun <= 1'b1;
`ifdef MAX1119X_DROP_CNT_EN
          if (drop_count != '1) drop_count <= drop_count + 16'd1;
`endif
        end
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      if (flags_clr) begin
        overrun     <= 1'b0;
        missed_tick <= 1'b0;
`ifdef MAX1119X_DROP_CNT_EN
        drop_count  <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_max1119x_conv_sched.sv
// Directed bench for max1119x_conv_sched with a behavioural ADC driving MISO from a per-frame word list.
module tb_max1119x_conv_sched;

  logic        clk = 1'b0;
  logic        reset, enable, single_shot, m_axis_tready, flags_clr;
  logic [31:0] period;
  logic        miso;
  logic        cs_n, sclk, busy, m_axis_tvalid, overrun, missed_tick;
  logic [15:0] m_axis_tdata;
`ifdef MAX1119X_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  int base = 0;
  int nf = 0;
  int nf0 = 0;
  int falls[64];
  int frame_rises[64];
  logic [15:0] words[8];
  int bit_idx = 0;
  int rises_in = 0;
  logic prev_sclk = 1'b0;
  logic prev_cs = 1'b1;
  logic [15:0] cur_word = '0;

  max1119x_conv_sched #(.CLK_DIV(2), .QUIET_CYCLES(4), .PERIOD_W(32)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .single_shot(single_shot), .miso(miso), .cs_n(cs_n), .sclk(sclk), .busy(busy),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .overrun(overrun), .missed_tick(missed_tick),
`ifdef MAX1119X_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .flags_clr(flags_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ADC model: presents the next bit after each observed SCLK rise
  always @(negedge clk) begin
    prev_cs   <= cs_n;
    prev_sclk <= sclk;
    if (prev_cs && !cs_n) begin
      falls[nf % 64] <= cyc_cnt;
      cur_word       <= words[(nf - nf0) % 8];
      nf             <= nf + 1;
      bit_idx        <= 0;
      rises_in       <= 0;
    end else if (!cs_n && sclk && !prev_sclk) begin
      bit_idx  <= bit_idx + 1;
      rises_in <= rises_in + 1;
    end
    if (!prev_cs && cs_n && nf > 0) frame_rises[(nf - 1) % 64] <= rises_in;
  end

  assign miso = (!cs_n && bit_idx < 16) ? cur_word[15 - bit_idx] : 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    base = cyc_cnt;
    nf0  = nf;
  endtask

  task automatic wait_to(input int c);
    while (cyc_cnt - base - 1 < c) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && busy; i++) step();
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  function automatic int rel_fall(input int i);
    return falls[(nf0 + i) % 64] - base - 1;
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b0; period = '0; single_shot = 1'b0;
    m_axis_tready = 1'b1; flags_clr = 1'b0;
    for (int i = 0; i < 8; i++) words[i] = '0;
    repeat (3) step();
    check("rst_cs_n",    {31'd0, cs_n}, 32'd1);
    check("rst_sclk",    {31'd0, sclk}, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_tvalid",  {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tdata",   {16'd0, m_axis_tdata}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_missed",  {31'd0, missed_tick}, 32'd0);
    reset = 1'b0;
    step();

    // single shot, 0xA5C3
    words[0] = 16'hA5C3;
    mark(); single_shot = 1'b1; step(); single_shot = 1'b0;
    check("ss_cs_fall", {31'd0, cs_n}, 32'd0);
    check("ss_busy0",   {31'd0, busy}, 32'd1);
    wait_to(67);
    check("ss_cs_67",   {31'd0, cs_n}, 32'd0);
    check("ss_tv_67",   {31'd0, m_axis_tvalid}, 32'd0);
    wait_to(68);
    check("ss_cs_68",   {31'd0, cs_n}, 32'd1);
    check("ss_tv_68",   {31'd0, m_axis_tvalid}, 32'd1);
    check("ss_tdata",   {16'd0, m_axis_tdata}, 32'h0000A5C3);
    wait_to(71);
    check("ss_busy71",  {31'd0, busy}, 32'd1);
    wait_to(72);
    check("ss_busy72",  {31'd0, busy}, 32'd0);
    check("ss_rises",   frame_rises[nf0 % 64], 32'd16);
    check("ss_frames",  nf - nf0, 32'd1);

    // period 0: back-to-back frames
    do_reset();
    for (int i = 0; i < 8; i++) words[i] = 16'h5A5A;
    mark(); enable = 1'b1; period = 32'd0; step();
    wait_to(150);
    check("p0_frames", nf - nf0, 32'd3);
    check("p0_fall0",  rel_fall(0), 32'd0);
    check("p0_fall1",  rel_fall(1), 32'd72);
    check("p0_fall2",  rel_fall(2), 32'd144);
    check("p0_rises0", frame_rises[nf0 % 64], 32'd16);
    check("p0_rises1", frame_rises[(nf0 + 1) % 64], 32'd16);
    check("p0_missed", {31'd0, missed_tick}, 32'd0);
    check("p0_tdata",  {16'd0, m_axis_tdata}, 32'h00005A5A);
    enable = 1'b0;
    wait_idle(200);

    // period 50: ticks outrun frames
    do_reset();
    mark(); enable = 1'b1; period = 32'd50; step();
    wait_to(199);
    check("p50_miss199", {31'd0, missed_tick}, 32'd0);
    wait_to(200);
    check("p50_miss200", {31'd0, missed_tick}, 32'd1);
    wait_to(220);
    check("p50_frames", nf - nf0, 32'd4);
    check("p50_fall1",  rel_fall(1), 32'd72);
    check("p50_fall2",  rel_fall(2), 32'd144);
    check("p50_fall3",  rel_fall(3), 32'd216);
    enable = 1'b0;
    wait_idle(200);
    step();
    check("p50_stop",   {31'd0, busy}, 32'd0);

    // overrun with tready low
    do_reset();
    m_axis_tready = 1'b0;
    words[0] = 16'h1234; words[1] = 16'hBEEF;
    mark(); single_shot = 1'b1; step(); single_shot = 1'b0;
    wait_to(9);
    single_shot = 1'b1; step(); single_shot = 1'b0;
    wait_to(69);
    check("ov_tv1",     {31'd0, m_axis_tvalid}, 32'd1);
    check("ov_tdata1",  {16'd0, m_axis_tdata}, 32'h00001234);
    check("ov_noov",    {31'd0, overrun}, 32'd0);
    wait_to(141);
    check("ov_fall1",   rel_fall(1), 32'd72);
    check("ov_hold",    {16'd0, m_axis_tdata}, 32'h00001234);
    check("ov_tv2",     {31'd0, m_axis_tvalid}, 32'd1);
    check("ov_flag",    {31'd0, overrun}, 32'd1);
    check("ov_missed",  {31'd0, missed_tick}, 32'd0);
`ifdef MAX1119X_DROP_CNT_EN
    check("ov_dropcnt", {16'd0, drop_count}, 32'd1);
`endif
    m_axis_tready = 1'b1;
    step();
    check("ov_hs",      {31'd0, m_axis_tvalid}, 32'd0);
    flags_clr = 1'b1; step(); flags_clr = 1'b0;
    check("ov_clr",     {31'd0, overrun}, 32'd0);
`ifdef MAX1119X_DROP_CNT_EN
    check("ov_dropclr", {16'd0, drop_count}, 32'd0);
`endif
    wait_idle(200);

    // reset mid-shift, then a clean frame
    do_reset();
    words[0] = 16'hFFFF;
    mark(); single_shot = 1'b1; step(); single_shot = 1'b0;
    wait_to(29);
    reset = 1'b1; step();
    check("mr_cs_n",   {31'd0, cs_n}, 32'd1);
    check("mr_sclk",   {31'd0, sclk}, 32'd0);
    check("mr_busy",   {31'd0, busy}, 32'd0);
    check("mr_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    reset = 1'b0;
    step();
    words[0] = 16'h3C5A;
    mark(); single_shot = 1'b1; step(); single_shot = 1'b0;
    wait_to(68);
    check("mr_tdata",  {16'd0, m_axis_tdata}, 32'h00003C5A);
    check("mr_tv",     {31'd0, m_axis_tvalid}, 32'd1);
    wait_to(69);
    check("mr_rises",  frame_rises[nf0 % 64], 32'd16);
    wait_idle(200);

    // two queued single-shots during a frame
    do_reset();
    words[0] = 16'h0F0F; words[1] = 16'hF0F0;
    mark(); single_shot = 1'b1; step(); single_shot = 1'b0;
    wait_to(9);
    single_shot = 1'b1; step(); single_shot = 1'b0;
    wait_to(19);
    check("sq_miss19", {31'd0, missed_tick}, 32'd0);
    single_shot = 1'b1; step(); single_shot = 1'b0;
    check("sq_miss20", {31'd0, missed_tick}, 32'd1);
    wait_to(200);
    check("sq_frames", nf - nf0, 32'd2);
    check("sq_fall1",  rel_fall(1), 32'd72);
    check("sq_tdata",  {16'd0, m_axis_tdata}, 32'h0000F0F0);
    check("sq_idle",   {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
